// File: rtl/input_manager_pkg.sv
// Shared types and defaults for the UART receive path: receiver FSM states,
// queue pointer type and default timing constants.
package uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 868;
    localparam int QLOG2_DEFAULT        = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    typedef logic [QLOG2_DEFAULT-1:0] qptr_t;

endpackage

// File: rtl/input_manager_if.sv
// Receive-queue bus between the UART pin side, the queue producer and the consuming core.
interface input_manager_if #(
    parameter int QLOG2 = 9
);
    logic             UART_RX;
    logic [7:0]       recv_queue [0:(1<<QLOG2)-1];
    logic [QLOG2-1:0] queue_t;
    logic [QLOG2-1:0] queue_s;
    logic             overflow;
    logic             frame_err;
    logic             err_clr;

    modport slave (
        input  UART_RX,
        input  queue_s,
        input  err_clr,
        output recv_queue,
        output queue_t,
        output overflow,
        output frame_err
    );

    modport master (
        output UART_RX,
        output queue_s,
        output err_clr,
        input  recv_queue,
        input  queue_t,
        input  overflow,
        input  frame_err
    );
endinterface

// File: rtl/input_manager_receiver.sv
// 8N1 UART deserialiser: 2-flop synchroniser plus start/data/stop FSM.
// Emits a one-cycle valid (good stop bit) or ferr (bad stop bit) pulse.
module receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       UART_RX,
    output logic [7:0] data,
    output logic       valid,
    output logic       ferr
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT/2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic            rx_meta_p0;
    logic            rx_s;
    rx_state_t       state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            vld_p1, vld_d;
    logic            ferr_p1, ferr_d;

    // Stage p0/p1: pin synchroniser, idles high so reset cannot fake a start bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= UART_RX;
            rx_s       <= rx_meta_p0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        vld_d   = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) state_d = START;
            end
            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        vld_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before another start is accepted
                cnt_d = '0;
                if (rx_s) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Stage p1: FSM control registers and result pulses
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            vld_p1  <= 1'b0;
            ferr_p1 <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            vld_p1  <= vld_d;
            ferr_p1 <= ferr_d;
        end
    end

    always_ff @(posedge CLK) begin
        shift_q <= shift_d;
    end

    assign data  = shift_q;
    assign valid = vld_p1;
    assign ferr  = ferr_p1;

endmodule

// File: rtl/input_manager.sv
// UART receive queue: appends deserialised bytes into a circular buffer whose
// head pointer is owned by the consumer; keeps sticky overflow/framing flags.
module input_manager
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int QLOG2        = QLOG2_DEFAULT
) (
    input logic             CLK,
    input logic             RST,
    input_manager_if.slave  bus
);
    localparam int DEPTH = 1 << QLOG2;

    logic [7:0]       rx_byte_p1;
    logic             rx_vld_p1;
    logic             rx_ferr_p1;
    logic [QLOG2-1:0] tail_q;
    logic [QLOG2-1:0] tail_inc;
    logic             full;
    logic             ovf_q;
    logic             ferr_q;
    logic [7:0]       queue_mem [0:DEPTH-1];

    receiver #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .CLK     (CLK),
        .RST     (RST),
        .UART_RX (bus.UART_RX),
        .data    (rx_byte_p1),
        .valid   (rx_vld_p1),
        .ferr    (rx_ferr_p1)
    );

    // One slot is always left empty so full and empty stay distinguishable
    assign tail_inc = tail_q + 1'b1;
    assign full     = (tail_inc == bus.queue_s);

    // Stage p2: queue write, pointer advance and sticky flags (set beats clear)
    always_ff @(posedge CLK) begin
        if (RST) begin
            tail_q <= '0;
            ovf_q  <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (rx_vld_p1 && !full) tail_q <= tail_inc;

            if (rx_vld_p1 && full) ovf_q <= 1'b1;
            else if (bus.err_clr)  ovf_q <= 1'b0;

            if (rx_ferr_p1)        ferr_q <= 1'b1;
            else if (bus.err_clr)  ferr_q <= 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (rx_vld_p1 && !full) queue_mem[tail_q] <= rx_byte_p1;
    end

    assign bus.recv_queue = queue_mem;
    assign bus.queue_t    = tail_q;
    assign bus.overflow   = ovf_q;
    assign bus.frame_err  = ferr_q;

endmodule

// File: tb/tb_input_manager.sv
// Directed bench for input_manager: frame table plus hand-written corner sequences.
module tb_input_manager;
    import uart_pkg::*;

    localparam int CPB = 8;
    localparam int QL  = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    input_manager_if #(.QLOG2(QL)) bus ();

    input_manager #(
        .CLKS_PER_BIT (CPB),
        .QLOG2        (QL)
    ) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_qt;
        logic       exp_ferr;
    } vec_t;

    vec_t vt [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        bus.UART_RX = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        bit_time(1'b0);
        for (int k = 0; k < 8; k++) bit_time(b[k]);
        bit_time(stop);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulse_clr();
        bus.err_clr = 1'b1;
        @(negedge clk);
        bus.err_clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.UART_RX = 1'b1;
        bus.queue_s = '0;
        bus.err_clr = 1'b0;
        vt[0] = '{8'hA5, 1'b1, 1, 1'b0};
        vt[1] = '{8'h00, 1'b1, 2, 1'b0};
        vt[2] = '{8'hFF, 1'b1, 3, 1'b0};
        vt[3] = '{8'h3C, 1'b0, 3, 1'b1};
        vt[4] = '{8'h81, 1'b1, 4, 1'b1};
        @(negedge clk);
        do_reset();

        check("reset_qt", 32'(bus.queue_t), 32'd0);
        check("reset_ovf", 32'(bus.overflow), 32'd0);
        check("reset_ferr", 32'(bus.frame_err), 32'd0);

        // Frame table; a bad-stop frame is followed by 3 bit times low then release
        for (int i = 0; i < 5; i++) begin
            send_frame(vt[i].data, vt[i].stop);
            if (!vt[i].stop) begin
                bus.UART_RX = 1'b0;
                repeat (3*CPB) @(negedge clk);
                bit_time(1'b1);
            end
            check($sformatf("tbl%0d_qt", i), 32'(bus.queue_t), 32'(vt[i].exp_qt));
            check($sformatf("tbl%0d_ferr", i), 32'(bus.frame_err), 32'(vt[i].exp_ferr));
            if (vt[i].stop)
                check($sformatf("tbl%0d_data", i), 32'(bus.recv_queue[vt[i].exp_qt-1]), 32'(vt[i].data));
        end
        pulse_clr();
        check("errclr_ferr", 32'(bus.frame_err), 32'd0);

        // Exact write latency: start edge at N0, queue_t moves between N0+79 and N0+80
        do_reset();
        fork
            send_frame(8'hA5, 1'b1);
            begin
                repeat (79) @(negedge clk);
                check("lat_qt_before", 32'(bus.queue_t), 32'd0);
                @(negedge clk);
                check("lat_qt_after", 32'(bus.queue_t), 32'd1);
            end
        join
        check("t1_data", 32'(bus.recv_queue[0]), 32'hA5);
        check("t1_ovf", 32'(bus.overflow), 32'd0);
        check("t1_ferr", 32'(bus.frame_err), 32'd0);

        // Short glitch on the idle line
        do_reset();
        bus.UART_RX = 1'b0;
        repeat (CPB/4) @(negedge clk);
        bus.UART_RX = 1'b1;
        repeat (3*CPB) @(negedge clk);
        check("glitch_qt", 32'(bus.queue_t), 32'd0);
        check("glitch_idle", 32'(dut.u_rx.state_q), 32'(IDLE));

        // Bad stop bit, line held low, then a good frame
        do_reset();
        send_frame(8'h3C, 1'b0);
        bus.UART_RX = 1'b0;
        repeat (3*CPB) @(negedge clk);
        bit_time(1'b1);
        send_frame(8'h55, 1'b1);
        check("brk_ferr", 32'(bus.frame_err), 32'd1);
        check("brk_qt", 32'(bus.queue_t), 32'd1);
        check("brk_data", 32'(bus.recv_queue[0]), 32'h55);

        // Fill to capacity, overflow, then free a slot and wrap
        do_reset();
        for (int i = 0; i < 511; i++) send_frame(8'(i), 1'b1);
        check("fill_qt", 32'(bus.queue_t), 32'd511);
        check("fill_ovf", 32'(bus.overflow), 32'd0);
        check("fill_d0", 32'(bus.recv_queue[0]), 32'h00);
        check("fill_d255", 32'(bus.recv_queue[255]), 32'hFF);
        check("fill_d256", 32'(bus.recv_queue[256]), 32'h00);
        check("fill_d510", 32'(bus.recv_queue[510]), 32'hFE);
        send_frame(8'hFF, 1'b1);
        check("ovf_qt", 32'(bus.queue_t), 32'd511);
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        bus.queue_s = 9'd1;
        pulse_clr();
        check("ovf_clr", 32'(bus.overflow), 32'd0);
        send_frame(8'h77, 1'b1);
        check("wrap_data", 32'(bus.recv_queue[511]), 32'h77);
        check("wrap_qt", 32'(bus.queue_t), 32'd0);
        check("wrap_ovf", 32'(bus.overflow), 32'd0);
        bus.queue_s = '0;

        // Reset pulse during the 4th data bit of an all-ones byte
        do_reset();
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b1);
        bit_time(1'b1);
        bus.UART_RX = 1'b1;
        repeat (CPB/2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (6*CPB) @(negedge clk);
        check("rstmid_qt", 32'(bus.queue_t), 32'd0);
        send_frame(8'hC3, 1'b1);
        check("rstmid_data", 32'(bus.recv_queue[0]), 32'hC3);
        check("rstmid_qt2", 32'(bus.queue_t), 32'd1);

        // Back-to-back frames with zero idle time
        do_reset();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        check("b2b_d0", 32'(bus.recv_queue[0]), 32'h00);
        check("b2b_d1", 32'(bus.recv_queue[1]), 32'hFF);
        check("b2b_qt", 32'(bus.queue_t), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
